// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Holds the architectural PC, issues one outstanding request at a time to
//   instruction memory and buffers {pc, instr} pairs in a small FIFO that is
//   drained by decode over a valid/ready handshake. A redirect reloads the PC
//   and squashes both the buffer and any in-flight fetch.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   redirect_valid/pc     load redirect_pc (low two bits ignored) as new PC
//   imem_req/addr         fetch request, held with a stable address until ack
//   imem_ack/rdata        request accepted, instruction word valid same cycle
//   inst_valid/ready      buffer head handshake towards decode
//   inst_out/pc           head instruction word and its PC (0 when empty)
//
// Optional build macro FETCH_PERF_EN adds saturating counters:
//   perf_fetched[31:0]    instructions popped by decode
//   perf_squashed[15:0]   buffered entries plus in-flight fetch lost to redirects
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_squashed
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FLUSH
    } state_t;

    state_t            state, state_next;
    logic [31:0]       pc;
    logic [31:0]       flush_addr;
    logic [31:0]       buf_pc    [BUF_DEPTH];
    logic [31:0]       buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count, count_next;
    logic              push, pop;

    assign imem_req   = (state != IDLE);
    // In FLUSH the squashed request is still outstanding, so its address
    // must stay on the bus while pc already holds the redirect target.
    assign imem_addr  = (state == FLUSH) ? flush_addr : pc;
    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? buf_instr[head] : '0;
    assign inst_pc    = inst_valid ? buf_pc[head]    : '0;

    // A redirect drops any same-cycle push or pop.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state == REQ) && imem_ack && !redirect_valid;

    always_comb begin
        count_next = count;
        if (redirect_valid) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            case (state)
                IDLE:    state_next = REQ;
                REQ:     state_next = imem_ack ? REQ : FLUSH;
                // An ack arriving with a second redirect retires the stale
                // request, so the new target can be fetched right away.
                FLUSH:   state_next = imem_ack ? REQ : FLUSH;
                default: state_next = REQ;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (count_next < FULL) state_next = REQ;
                end
                REQ: begin
                    if (imem_ack && (count_next >= FULL)) state_next = IDLE;
                end
                FLUSH: begin
                    if (imem_ack) state_next = (count_next < FULL) ? REQ : IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            flush_addr <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (redirect_valid) begin
                pc   <= redirect_pc & ~32'd3;
                head <= '0;
                tail <= '0;
                if ((state == REQ) && !imem_ack) flush_addr <= pc;
            end else begin
                if (push) begin
                    pc   <= pc + 32'd4;
                    tail <= (tail == LAST) ? '0 : tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= (head == LAST) ? '0 : head + PTR_W'(1);
                end
            end
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail]    <= pc;
            buf_instr[tail] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [16:0] squash_sum;

    always_comb begin
        squash_sum = 17'(perf_squashed) + 17'(count) + ((state == REQ) ? 17'd1 : 17'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (pop && (perf_fetched != '1)) perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid) perf_squashed <= squash_sum[16] ? '1 : squash_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_squashed;
`endif

    int checks = 0;
    int failures = 0;

    fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out(inst_out),
        .inst_pc(inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_squashed(perf_squashed)
`endif
    );

    always #5 clk = ~clk;

    // Fresh random instruction word every cycle.
    always @(posedge clk) begin
        #1;
        imem_rdata = $urandom;
    end

    // Reference model: in-order queue of fetched {pc, instr}, next fetch PC,
    // and whether the outstanding request belongs to a squashed stream.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = RPC;
    logic [31:0] m_flush = RPC;
    bit          m_stale = 0;
    bit          m_exp_req = 0;
    longint      m_fetched = 0;
    longint      m_squashed = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_pc = RPC;
            m_flush = RPC;
            m_stale = 0;
            m_exp_req = 0;
            m_fetched = 0;
            m_squashed = 0;
        end else begin
            checks++;
            if (imem_req !== m_exp_req) begin
                failures++;
                $display("FAIL mon_req actual=%0b required=%0b t=%0t", imem_req, m_exp_req, $time);
            end
            if (m_exp_req && !m_stale) begin
                checks++;
                if (imem_addr !== m_pc) begin
                    failures++;
                    $display("FAIL mon_fetch_addr actual=%h required=%h t=%0t", imem_addr, m_pc, $time);
                end
            end
            if (m_exp_req && m_stale) begin
                checks++;
                if (imem_addr !== m_flush) begin
                    failures++;
                    $display("FAIL mon_flush_addr actual=%h required=%h t=%0t", imem_addr, m_flush, $time);
                end
            end
            checks++;
            if (inst_valid !== (q.size() != 0)) begin
                failures++;
                $display("FAIL mon_valid actual=%0b required=%0b t=%0t", inst_valid, q.size() != 0, $time);
            end
            checks++;
            if (q.size() != 0) begin
                if (inst_pc !== q[0].pc || inst_out !== q[0].instr) begin
                    failures++;
                    $display("FAIL mon_head actual=%h/%h required=%h/%h t=%0t",
                             inst_pc, inst_out, q[0].pc, q[0].instr, $time);
                end
            end else if (inst_pc !== '0 || inst_out !== '0) begin
                failures++;
                $display("FAIL mon_empty_out actual=%h/%h required=0/0 t=%0t", inst_pc, inst_out, $time);
            end
`ifdef FETCH_PERF_EN
            checks++;
            if (perf_fetched !== 32'(m_fetched) || perf_squashed !== 16'((m_squashed > 65535) ? 65535 : m_squashed)) begin
                failures++;
                $display("FAIL mon_perf actual=%0d/%0d required=%0d/%0d", perf_fetched, perf_squashed, m_fetched, m_squashed);
            end
`endif
            if (redirect_valid) begin
                if (m_exp_req && !imem_ack && !m_stale) m_flush = m_pc;
                m_squashed += q.size() + ((m_exp_req && !m_stale) ? 1 : 0);
                m_stale = m_exp_req && !imem_ack;
                q.delete();
                m_pc = redirect_pc & ~32'd3;
            end else begin
                if (q.size() != 0 && inst_ready) begin
                    void'(q.pop_front());
                    m_fetched++;
                end
                if (m_exp_req && imem_ack) begin
                    if (m_stale) m_stale = 0;
                    else begin
                        q.push_back('{pc: m_pc, instr: imem_rdata});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
            m_exp_req = (q.size() < DEPTH);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; reset is seen low by one falling edge.
    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req actual=%0b required=0", imem_req); end
        checks++;
        if (imem_addr !== RPC) begin failures++; $display("FAIL rst_addr actual=%h required=%h", imem_addr, RPC); end
        checks++;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid actual=%0b required=0", inst_valid); end
        checks++;
        if (inst_out !== '0 || inst_pc !== '0) begin
            failures++; $display("FAIL rst_inst actual=%h/%h required=0/0", inst_out, inst_pc);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        inst_ready = 1'b1;
        imem_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL stream_first_req actual=%0b/%0b required=0/1", inst_valid, imem_req);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== RPC + 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_pc actual=%0b/%h required=1/%h", inst_valid, inst_pc, RPC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        cyc();
        inst_ready = 1'b0;
        imem_ack = 1'b1;
        pulse_reset();
        repeat (3) cyc();
        checks++;
        if (imem_req !== 1'b0 || inst_pc !== RPC) begin
            failures++; $display("FAIL bp_full actual=%0b/%h required=0/%h", imem_req, inst_pc, RPC);
        end
        repeat (2) cyc();
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
            failures++; $display("FAIL bp_hold actual=%0b/%0b required=0/1", imem_req, inst_valid);
        end
        inst_ready = 1'b1;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || inst_pc !== RPC + 32'd4 || imem_addr !== RPC + 32'd8) begin
            failures++;
            $display("FAIL bp_resume actual=%0b/%h/%h required=1/%h/%h", imem_req, inst_pc, imem_addr, RPC + 32'd4, RPC + 32'd8);
        end
        cyc();
        checks++;
        if (inst_pc !== RPC + 32'd8) begin
            failures++; $display("FAIL bp_order actual=%h required=%h", inst_pc, RPC + 32'd8);
        end
    endtask

    task automatic test_redirect_ack();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1000;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h1000) begin
            failures++;
            $display("FAIL redir_ack actual=%0b/%0b/%h required=0/1/00001000", inst_valid, imem_req, imem_addr);
        end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h1000 || imem_addr !== 32'h1004) begin
            failures++;
            $display("FAIL redir_ack_next actual=%0b/%h/%h required=1/00001000/00001004", inst_valid, inst_pc, imem_addr);
        end
    endtask

    task automatic test_redirect_flush();
        imem_ack = 1'b0;
        inst_ready = 1'b1;
        pulse_reset();
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            redirect_valid = 1'b0;
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== RPC || inst_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_hold actual=%0b/%h/%0b required=1/%h/0", imem_req, imem_addr, inst_valid, RPC);
            end
        end
        imem_ack = 1'b1;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h2000 || inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_done actual=%0b/%h/%0b required=1/00002000/0", imem_req, imem_addr, inst_valid);
        end
        cyc();
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h2000) begin
            failures++; $display("FAIL flush_first actual=%0b/%h required=1/00002000", inst_valid, inst_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect_valid = 1'b0;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_addr actual=%h required=fffffffc", imem_addr);
        end
        cyc();
        checks++;
        if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_next actual=%h/%h required=00000000/fffffffc", imem_addr, inst_pc);
        end
        cyc();
        checks++;
        if (inst_pc !== 32'h0) begin
            failures++; $display("FAIL wrap_pc actual=%h required=00000000", inst_pc);
        end
    endtask

    task automatic test_reset_mid();
        imem_ack = 1'b0;
        cyc();
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_req_pending actual=%0b required=1", imem_req); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RPC || inst_valid !== 1'b0 || inst_out !== '0 || inst_pc !== '0) begin
            failures++;
            $display("FAIL mid_reset actual=%0b/%h/%0b/%h/%h required=0/%h/0/0/0",
                     imem_req, imem_addr, inst_valid, inst_out, inst_pc, RPC);
        end
        cyc();
        rst_n = 1'b1;
        imem_ack = 1'b1;
        cyc();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            failures++; $display("FAIL mid_first_req actual=%0b/%h required=1/%h", imem_req, imem_addr, RPC);
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        inst_ready = 1'b0;
        imem_ack = 1'b1;
        pulse_reset();
        repeat (3) cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        imem_ack = 1'b0;
        cyc();
        checks++;
        if (perf_squashed !== 16'd2) begin
            failures++; $display("FAIL perf_sq_buf actual=%0d required=2", perf_squashed);
        end
        cyc();
        checks++;
        if (perf_squashed !== 16'd3) begin
            failures++; $display("FAIL perf_sq_inflight actual=%0d required=3", perf_squashed);
        end
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        repeat (3) cyc();
    endtask
`endif

    task automatic test_random();
        inst_ready = 1'b1;
        imem_ack = 1'b1;
        pulse_reset();
        for (int n = 0; n < 800; n++) begin
            imem_ack = ($urandom_range(0, 99) < 60);
            inst_ready = ($urandom_range(0, 99) < 65);
            redirect_valid = ($urandom_range(0, 99) < 6);
            redirect_pc = $urandom;
            cyc();
        end
        redirect_valid = 1'b0;
        repeat (2) cyc();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_ack();
        test_redirect_flush();
        test_wrap();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        test_random();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
